sent_nibble_packer: RTL



---
 rtl/sent_nibble_packer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sent_nibble_packer.sv
// Packs SENT data nibbles MSB-first into DATASIZE-bit words and queues them for the async FIFO write port.
// Optional macro SENT_DROP_CNT_EN: implements the saturating drop_cnt overflow counter (otherwise drop_cnt is 0).
module sent_nibble_packer #(
    parameter int DATASIZE = 12,
    parameter int QDEPTH   = 2,
    parameter int CNTW     = 8
) (
    input  logic                write_clk,
    input  logic                read_reset,
    input  logic                nib_valid,
    input  logic [3:0]          nib_data,
    input  logic                nib_sof,
    input  logic                nib_eof,
    input  logic                write_full,
    output logic                write_enable,
    output logic [DATASIZE-1:0] write_data,
    output logic                frame_err,
    output logic [CNTW-1:0]     drop_cnt
);

    localparam int NIBS = DATASIZE / 4;
    localparam int KW   = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam int PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [KW-1:0]       k, k_nxt;
    logic [KW-1:0]       k_eff;
    logic [DATASIZE-1:0] shreg, shreg_nxt;
    logic [DATASIZE-1:0] base;
    logic [DATASIZE-1:0] word;
    logic                word_done;
    logic                err_nxt;

    always_ff @(posedge write_clk or posedge read_reset) begin
        if (read_reset) begin
            state     <= IDLE;
            k         <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            shreg     <= shreg_nxt;
            frame_err <= err_nxt;
        end
    end

    // A sof nibble always restarts the word; one arriving mid-word discards the partial word.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        shreg_nxt = shreg;
        err_nxt   = 1'b0;
        word_done = 1'b0;
        k_eff     = k;
        base      = shreg;
        word      = shreg;
        if (nib_valid) begin
            if ((state == IDLE) || nib_sof) begin
                k_eff = '0;
                base  = '0;
                if (state == ACC) begin
                    err_nxt = 1'b1;
                end
            end
            word = base | (DATASIZE'(nib_data) << (DATASIZE - 4 - 4 * int'(k_eff)));
            if (int'(k_eff) == NIBS - 1) begin
                word_done = 1'b1;
                state_nxt = IDLE;
                k_nxt     = '0;
                shreg_nxt = '0;
            end else if (nib_eof) begin
                err_nxt   = 1'b1;
                state_nxt = IDLE;
                k_nxt     = '0;
                shreg_nxt = '0;
            end else begin
                state_nxt = ACC;
                k_nxt     = k_eff + 1'b1;
                shreg_nxt = word;
            end
        end
    end

    // Handshake: write_enable means the head word is valid; it is consumed at any edge where
    // write_enable is high and write_full is low, and is held stable otherwise.
    logic [DATASIZE-1:0] mem [QDEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [PW:0]         count;
    logic                pop, push;

    assign write_enable = (count != '0);
    assign write_data   = mem[rd_ptr];
    assign pop          = write_enable && !write_full;
    // A pop at the same edge frees the slot, so a full queue still accepts the word.
    assign push         = word_done && ((int'(count) < QDEPTH) || pop);

    always_ff @(posedge write_clk or posedge read_reset) begin
        if (read_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef SENT_DROP_CNT_EN
    logic            drop;
    logic [CNTW-1:0] drop_q;

    assign drop     = word_done && !push;
    assign drop_cnt = drop_q;

    always_ff @(posedge write_clk or posedge read_reset) begin
        if (read_reset) begin
            drop_q <= '0;
        end else if (drop && (drop_q != {CNTW{1'b1}})) begin
            drop_q <= drop_q + 1'b1;
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule
